// File: rtl/ahb_mtx_input_stage_pkg.sv
// Shared AHB encodings, control-field layout and input-stage state type
// used by the matrix input stage.
package ahb_mtx_input_stage_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // ctrl_dec layout: {write, size[2:0], burst[2:0], mastlock}
  localparam int unsigned CTRL_W         = 8;
  localparam int unsigned CTRL_LOCK      = 0;
  localparam int unsigned CTRL_BURST_LSB = 1;
  localparam int unsigned CTRL_SIZE_LSB  = 4;
  localparam int unsigned CTRL_WRITE     = 7;

  // Bit 1 = transfer held pending, bit 0 = data phase outstanding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DATA      = 2'b01,
    ST_PEND      = 2'b10,
    ST_PEND_DATA = 2'b11
  } in_state_e;

  function automatic logic trans_is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic       write,
    input logic [2:0] size,
    input logic [2:0] burst,
    input logic       lock
  );
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_WRITE]               = write;
    c[CTRL_SIZE_LSB +: 3]       = size;
    c[CTRL_BURST_LSB +: 3]      = burst;
    c[CTRL_LOCK]                = lock;
    return c;
  endfunction

endpackage

// File: rtl/ahb_mtx_input_stage.sv
// AHB matrix input stage: passes master address phases to the decoder and
// holds any that the granted output port cannot accept in the same cycle.
module ahb_mtx_input_stage
  import ahb_mtx_input_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_dec,
  output logic [ADDR_W-1:0] addr_dec,
  output logic [1:0]        trans_dec,
  output logic [7:0]        ctrl_dec,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic [1:0]        resp_dec
);

  in_state_e state, state_next;

  logic pend_tran;
  logic data_phase;
  logic sample_valid;
  logic accept;
  logic load;
  logic next_pend;
  logic next_data;
  logic use_hold;

  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_trans;
  logic [CTRL_W-1:0] hold_ctrl;
  logic [CTRL_W-1:0] live_ctrl;

  assign pend_tran  = (state == ST_PEND) || (state == ST_PEND_DATA);
  assign data_phase = (state == ST_DATA) || (state == ST_PEND_DATA);
  assign live_ctrl  = pack_ctrl(HWRITES, HSIZES, HBURSTS, HMASTLOCKS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // While a transfer is held the master is stalled, so only active_dec
  // matters; otherwise a live valid sample is either accepted or captured.
  always_comb begin
    sample_valid = HSELS && trans_is_active(HTRANSS) && HREADYS;
    accept       = 1'b0;
    load         = 1'b0;
    next_pend    = 1'b0;
    if (pend_tran) begin
      accept    = active_dec;
      next_pend = !active_dec;
    end else begin
      accept    = sample_valid && active_dec;
      load      = sample_valid && !active_dec;
      next_pend = load;
    end
    if (accept) begin
      next_data = 1'b1;
    end else if (readyout_dec) begin
      next_data = 1'b0;
    end else begin
      next_data = data_phase;
    end
    state_next = in_state_e'({next_pend, next_data});
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_ctrl  <= '0;
    end else if (load) begin
      hold_addr  <= HADDRS;
      hold_trans <= HTRANSS;
      hold_ctrl  <= live_ctrl;
    end
  end

  // Reset overrides the state bits combinationally so a discarded transfer
  // never shows a stall or a response during the reset cycle itself.
  always_comb begin
    use_hold   = pend_tran && !HRESET;
    sel_dec    = HSELS;
    addr_dec   = HADDRS;
    trans_dec  = HTRANSS;
    ctrl_dec   = live_ctrl;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (use_hold) begin
      sel_dec   = 1'b1;
      addr_dec  = hold_addr;
      trans_dec = hold_trans;
      ctrl_dec  = hold_ctrl;
    end
    if (!HRESET) begin
      if (pend_tran) begin
        HREADYOUTS = 1'b0;
      end else if (data_phase) begin
        HREADYOUTS = readyout_dec;
      end
      if (data_phase) begin
        HRESPS = resp_dec;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed bench for ahb_mtx_input_stage: inputs change on the falling edge,
// outputs are checked 1 ns later, state advances on the rising edge.
module tb_ahb_mtx_input_stage;

  localparam int unsigned ADDR_W = 32;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;
  logic              sel_dec;
  logic [ADDR_W-1:0] addr_dec;
  logic [1:0]        trans_dec;
  logic [7:0]        ctrl_dec;
  logic              active_dec;
  logic              readyout_dec;
  logic [1:0]        resp_dec;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  ahb_mtx_input_stage #(.ADDR_W(ADDR_W)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSELS       (HSELS),
    .HADDRS      (HADDRS),
    .HTRANSS     (HTRANSS),
    .HWRITES     (HWRITES),
    .HSIZES      (HSIZES),
    .HBURSTS     (HBURSTS),
    .HMASTLOCKS  (HMASTLOCKS),
    .HREADYS     (HREADYS),
    .HREADYOUTS  (HREADYOUTS),
    .HRESPS      (HRESPS),
    .sel_dec     (sel_dec),
    .addr_dec    (addr_dec),
    .trans_dec   (trans_dec),
    .ctrl_dec    (ctrl_dec),
    .active_dec  (active_dec),
    .readyout_dec(readyout_dec),
    .resp_dec    (resp_dec)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic master(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size, input logic [2:0] burst,
                        input logic lock, input logic rdy);
    HSELS      = sel;
    HTRANSS    = trans;
    HADDRS     = addr;
    HWRITES    = wr;
    HSIZES     = size;
    HBURSTS    = burst;
    HMASTLOCKS = lock;
    HREADYS    = rdy;
  endtask

  task automatic slave(input logic act, input logic rdy, input logic [1:0] resp);
    active_dec   = act;
    readyout_dec = rdy;
    resp_dec     = resp;
  endtask

  task automatic next_cycle();
    @(negedge HCLK);
  endtask

  initial begin
    HRESET = 1'b1;
    master(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 2'b00);

    // Reset values
    next_cycle(); #1;
    chk("rst_readyout", HREADYOUTS, 1);
    chk("rst_resp", HRESPS, 0);
    chk("rst_sel0", sel_dec, 0);
    HSELS = 1'b1; #1;
    chk("rst_sel1", sel_dec, 1);

    // IDLE passes straight through
    next_cycle(); HRESET = 1'b0;
    master(1'b1, 2'b00, 32'h55, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1); #1;
    chk("idle_trans", trans_dec, 0);
    chk("idle_addr", addr_dec, 32'h55);
    chk("idle_ready", HREADYOUTS, 1);

    // NONSEQ 0x1000 accepted immediately
    next_cycle();
    master(1'b1, 2'b10, 32'h1000, 1'b1, 3'd2, 3'd0, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 2'b00); #1;
    chk("ns1_addr", addr_dec, 32'h1000);
    chk("ns1_trans", trans_dec, 2);
    chk("ns1_ctrl", ctrl_dec, 8'hA0);
    chk("ns1_sel", sel_dec, 1);
    chk("ns1_ready", HREADYOUTS, 1);
    next_cycle();
    master(1'b1, 2'b00, 32'h1234, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 2'b00); #1;
    chk("ns1_dp_ready", HREADYOUTS, 1);
    chk("ns1_nohold_addr", addr_dec, 32'h1234);

    // NONSEQ 0x2000 stalled three cycles, master changes address meanwhile
    next_cycle();
    master(1'b1, 2'b10, 32'h2000, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1);
    slave(1'b0, 1'b1, 2'b00); #1;
    chk("ns2_live_addr", addr_dec, 32'h2000);
    chk("ns2_live_ready", HREADYOUTS, 1);
    next_cycle();
    master(1'b0, 2'b11, 32'h3000, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0); #1;
    chk("hold1_ready", HREADYOUTS, 0);
    chk("hold1_addr", addr_dec, 32'h2000);
    chk("hold1_trans", trans_dec, 2);
    chk("hold1_ctrl", ctrl_dec, 8'h17);
    chk("hold1_sel", sel_dec, 1);
    chk("hold1_resp", HRESPS, 0);
    next_cycle(); #1;
    chk("hold2_ready", HREADYOUTS, 0);
    chk("hold2_addr", addr_dec, 32'h2000);
    next_cycle();
    slave(1'b1, 1'b1, 2'b00); #1;
    chk("hold3_ready", HREADYOUTS, 0);
    chk("hold3_addr", addr_dec, 32'h2000);
    next_cycle();
    master(1'b0, 2'b00, 32'h3000, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b0, 2'b00); #1;
    chk("rel_dp_ready0", HREADYOUTS, 0);
    chk("rel_addr", addr_dec, 32'h3000);
    chk("rel_sel", sel_dec, 0);
    next_cycle();
    slave(1'b0, 1'b1, 2'b00); #1;
    chk("rel_dp_ready1", HREADYOUTS, 1);

    // Two-cycle ERROR response
    next_cycle();
    master(1'b1, 2'b10, 32'h4000, 1'b1, 3'd2, 3'd0, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 2'b00);
    next_cycle();
    master(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    slave(1'b0, 1'b0, 2'b01); #1;
    chk("err1_resp", HRESPS, 1);
    chk("err1_ready", HREADYOUTS, 0);
    next_cycle();
    HREADYS = 1'b1;
    slave(1'b0, 1'b1, 2'b01); #1;
    chk("err2_resp", HRESPS, 1);
    chk("err2_ready", HREADYOUTS, 1);
    next_cycle(); #1;
    chk("err_after_resp", HRESPS, 0);

    // Reset while a transfer is held
    next_cycle();
    master(1'b1, 2'b10, 32'h5000, 1'b0, 3'd2, 3'd0, 1'b0, 1'b1);
    slave(1'b0, 1'b1, 2'b00);
    next_cycle();
    HREADYS = 1'b0; #1;
    chk("rstp_pend_ready", HREADYOUTS, 0);
    HRESET = 1'b1;
    master(1'b0, 2'b00, 32'h6000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1); #1;
    chk("rstp_in_ready", HREADYOUTS, 1);
    chk("rstp_in_sel", sel_dec, 0);
    next_cycle();
    HRESET = 1'b0; #1;
    chk("rstp_ready", HREADYOUTS, 1);
    chk("rstp_sel", sel_dec, 0);
    chk("rstp_addr", addr_dec, 32'h6000);
    chk("rstp_resp", HRESPS, 0);

    // Back-to-back NONSEQ/SEQ, both accepted
    next_cycle();
    master(1'b1, 2'b10, 32'h7000, 1'b0, 3'd2, 3'd1, 1'b0, 1'b1);
    slave(1'b1, 1'b1, 2'b00); #1;
    chk("b2b_ns_addr", addr_dec, 32'h7000);
    next_cycle();
    master(1'b1, 2'b11, 32'h7004, 1'b0, 3'd2, 3'd1, 1'b0, 1'b1); #1;
    chk("b2b_seq_ready", HREADYOUTS, 1);
    chk("b2b_seq_trans", trans_dec, 3);
    chk("b2b_seq_addr", addr_dec, 32'h7004);
    next_cycle();
    master(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    slave(1'b0, 1'b0, 2'b00); #1;
    chk("b2b_dp_held", HREADYOUTS, 0);
    next_cycle();
    HREADYS = 1'b1;
    slave(1'b0, 1'b1, 2'b00); #1;
    chk("b2b_dp_done", HREADYOUTS, 1);
    next_cycle();
    slave(1'b0, 1'b0, 2'b01); #1;
    chk("b2b_dp_clear", HREADYOUTS, 1);
    chk("b2b_resp_clear", HRESPS, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_input_stage.md
AHB_MTX_INPUT_STAGE -- requirements
Module: ahb_mtx_input_stage

Interface
REQ-001 Parameter: ADDR_W, default 32, address width.
REQ-002 HCLK  in  1  bus clock; the only clock.
REQ-003 HRESET  in  1  reset, synchronous, active-high.
REQ-004 HSELS  in  1  slave-port select from master.
REQ-005 HADDRS  in  ADDR_W  master address.
REQ-006 HTRANSS  in  2  master transfer type.
REQ-007 HWRITES  in  1  master write flag.
REQ-008 HSIZES  in  3  master transfer size.
REQ-009 HBURSTS  in  3  master burst type.
REQ-010 HMASTLOCKS  in  1  master lock.
REQ-011 HREADYS  in  1  bus HREADY seen by master.
REQ-012 HREADYOUTS  out  1  ready returned to master.
REQ-013 HRESPS  out  2  response returned to master.
REQ-014 sel_dec  out  1  select to decoder/arbiter.
REQ-015 addr_dec  out  ADDR_W  address to decoder/arbiter.
REQ-016 trans_dec  out  2  transfer type to decoder/arbiter.
REQ-017 ctrl_dec  out  8  {write, size[2:0], burst[2:0], mastlock}.
REQ-018 active_dec  in  1  address phase accepted by the granted output port this cycle.
REQ-019 readyout_dec  in  1  data-phase ready from the output port.
REQ-020 resp_dec  in  2  data-phase response from the output port.

Function
REQ-021 Sample: an address phase is valid when HSELS=1, HTRANSS[1]=1 and HREADYS=1.
REQ-022 Holding register: a valid address phase with active_dec=0 in the same cycle shall be captured at the next HCLK edge (addr, trans, ctrl) and set pend_tran=1.
REQ-023 Pass-through: with pend_tran=0, the *_dec outputs shall equal the live master inputs combinationally (zero-cycle latency).
REQ-024 Held drive: with pend_tran=1, the *_dec outputs shall come from the holding register, with sel_dec=1.
REQ-025 Release: pend_tran shall clear at the edge where pend_tran=1 and active_dec=1; the held transfer then enters its data phase.
REQ-026 Data-phase tracking: data_phase shall be set at any edge where a transfer (live or held) is accepted with active_dec=1, and cleared at an edge with readyout_dec=1 and no new acceptance.
REQ-027 HREADYOUTS: 0 while pend_tran=1; otherwise readyout_dec while data_phase=1; otherwise 1.
REQ-028 HRESPS: resp_dec while data_phase=1; otherwise OKAY (2'b00); OKAY while pend_tran=1 and data_phase=0.
REQ-029 Simultaneous events: a valid sample with active_dec=1 and pend_tran=0 shall not load the holding register.
REQ-030 The master cannot present a new sample while pend_tran=1, because HREADYOUTS=0 forces HREADYS low through the bus.
REQ-031 IDLE and BUSY transfers (HTRANSS[1]=0) shall never be held; they pass through to trans_dec.
REQ-032 ERROR response: HRESPS shall follow resp_dec across both ERROR cycles. A pending transfer is not cancelled by this block; it is released only by active_dec.
REQ-033 Lock: a held transfer keeps its captured mastlock in ctrl_dec until released.

Reset
REQ-034 While HRESET=1 at an HCLK edge: pend_tran=0, data_phase=0, holding register=0.
REQ-035 Output values in reset: HREADYOUTS=1, HRESPS=00, sel_dec follows HSELS. Reset asserted mid-pend or mid-data-phase shall discard the transfer with no completion signalled.

Structure
REQ-036 Shared package holds the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), the HRESP encodings (OKAY=00, ERROR=01) and the ctrl_dec field offsets.
REQ-037 The block is a single module with no sub-modules; the holding register and the two state bits are internal.

Verification
REQ-038 NONSEQ to 0x1000 with active_dec=1, readyout_dec=1 -> addr_dec=0x1000 in the same cycle, no hold, HREADYOUTS=1 in the next cycle.
REQ-039 NONSEQ to 0x2000 with active_dec=0 for 3 cycles, then 1 -> HREADYOUTS=0 for 3 cycles, addr_dec held at 0x2000, pend_tran clears on the 4th edge.
REQ-040 Held transfer while the master changes HADDRS to 0x3000 -> addr_dec stays 0x2000 until release.
REQ-041 resp_dec=ERROR with readyout_dec=0 then 1 -> HRESPS=01 for both cycles, HREADYOUTS=0 then 1.
REQ-042 HRESET=1 while pend_tran=1 -> next cycle pend_tran=0, HREADYOUTS=1, sel_dec follows HSELS.
REQ-043 Back-to-back NONSEQ/SEQ pair, both accepted, with readyout_dec=1 -> no holds, data_phase stays 1 across both.
